// File: rtl/alu_iterative.sv
// alu_iterative
// Execute-stage ALU with a valid/ready handshake. Logic, compare, add/sub and
// shift codes complete with one-cycle registered latency; MUL (and DIVU/REMU
// when ALU_DIV_EN is defined) run one step per cycle on a shared iterative
// datapath, so the pipeline stalls through in_ready while they are busy.
//
// Build option: ALU_DIV_EN -- when defined, builds the restoring divider for
// DIVU/REMU. When undefined, codes 1110/1111 return 0 with latency 1.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   flush      abort any in-flight operation, discard its result
//   in_valid   SrcA/SrcB/Operation valid
//   in_ready   block can accept an operation (IDLE only)
//   SrcA/SrcB  operands (shift amount = low log2(DATA_WIDTH) bits of SrcB)
//   Operation  operation code
//   out_valid  ALUResult valid
//   out_ready  consumer takes the result
//   ALUResult  registered result
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | iterative MUL/DIVU/REMU, one step per cycle
// DONE  | result held on ALUResult, out_valid=1 until out_ready
module alu_iterative #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL = OPCODE_LENGTH'(4'b1101);
`ifdef ALU_DIV_EN
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU = OPCODE_LENGTH'(4'b1111);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   a_reg, b_reg, acc;
    logic [DATA_WIDTH-1:0]   a_next, b_next, acc_next, iter_result;
    logic [DATA_WIDTH-1:0]   sc_result;
    logic                    is_iter;
    logic [SW-1:0]           shamt;
`ifdef ALU_DIV_EN
    logic [OPCODE_LENGTH-1:0] op_reg;
    logic [DATA_WIDTH:0]      rem_sh;
`endif

    assign shamt     = SrcB[SW-1:0];
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);

    // Single-cycle result, and whether the code needs the iterative datapath.
    always_comb begin
        sc_result = '0;
        is_iter   = 1'b0;
        case (Operation)
            OP_AND: sc_result = SrcA & SrcB;
            OP_OR:  sc_result = SrcA | SrcB;
            OP_ADD: sc_result = SrcA + SrcB;
            OP_SLL: sc_result = SrcA << shamt;
            OP_SRL: sc_result = SrcA >> shamt;
            OP_SUB: sc_result = SrcA - SrcB;
            OP_SRA: sc_result = $signed(SrcA) >>> shamt;
            OP_SLT: sc_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_EQ:  sc_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_NE:  sc_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
            OP_LT:  sc_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_GE:  sc_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA >= SrcB)};
            OP_XOR: sc_result = SrcA ^ SrcB;
            OP_MUL: is_iter   = 1'b1;
`ifdef ALU_DIV_EN
            // Divide by zero is resolved immediately instead of iterating.
            OP_DIVU: begin
                if (SrcB == '0) sc_result = '1;
                else            is_iter   = 1'b1;
            end
            OP_REMU: begin
                if (SrcB == '0) sc_result = SrcA;
                else            is_iter   = 1'b1;
            end
`endif
            default: sc_result = '0;
        endcase
    end

    // One iteration step. MUL: acc accumulates a_reg shifted left while b_reg
    // shifts right. DIVU/REMU: a_reg holds the dividend shifting out MSB-first
    // with quotient bits shifting in, acc holds the partial remainder.
    always_comb begin
        acc_next = acc + (b_reg[0] ? a_reg : '0);
        a_next   = a_reg << 1;
        b_next   = b_reg >> 1;
`ifdef ALU_DIV_EN
        rem_sh   = {acc, a_reg[DATA_WIDTH-1]};
        if (op_reg != OP_MUL) begin
            b_next = b_reg;
            if (rem_sh >= {1'b0, b_reg}) begin
                acc_next = DATA_WIDTH'(rem_sh - {1'b0, b_reg});
                a_next   = {a_reg[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_sh[DATA_WIDTH-1:0];
                a_next   = {a_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
        iter_result = (op_reg == OP_DIVU) ? a_next : acc_next;
`else
        iter_result = acc_next;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = is_iter ? BUSY : DONE;
            BUSY: if (cnt == CW'(1)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            ALUResult <= '0;
`ifdef ALU_DIV_EN
            op_reg    <= '0;
`endif
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                if (is_iter) begin
                    cnt   <= CW'(DATA_WIDTH);
                    a_reg <= SrcA;
                    b_reg <= SrcB;
                    acc   <= '0;
`ifdef ALU_DIV_EN
                    op_reg <= Operation;
`endif
                end else begin
                    ALUResult <= sc_result;
                end
            end else if (state == BUSY) begin
                cnt   <= cnt - CW'(1);
                a_reg <= a_next;
                b_reg <= b_next;
                acc   <= acc_next;
                if (cnt == CW'(1)) ALUResult <= iter_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;

    alu_iterative #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the operation table.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a << sh;
            4'd4:  r = a >> sh;
            4'd5:  r = a - b;
            4'd6:  r = $signed(a) >>> sh;
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = (a == b) ? 32'd1 : 32'd0;
            4'd9:  r = (a != b) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: r = (a >= b) ? 32'd1 : 32'd0;
            4'd12: r = a ^ b;
            4'd13: r = a * b;
            4'd14: r = !DIV_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: r = !DIV_EN ? 32'd0 : (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from accept to the DONE state: 0 for single-cycle, 32 iterative.
    function automatic int ref_after(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd13) return 32;
        if (DIV_EN && (op == 4'd14 || op == 4'd15) && b != 0) return 32;
        return 0;
    endfunction

    // Transaction-level model: one pending operation with its accept cycle.
    bit          pending = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          after = 0;
    logic [31:0] exp_res = '0;
    bit          m_ready, m_valid;

    always @(posedge clk) begin
        m_ready = !pending && !reset;
        m_valid = pending && (cyc - acc_cyc >= after);
        if (reset) pending = 1'b0;
        else if (flush) pending = 1'b0;
        else if (m_ready && in_valid) begin
            pending = 1'b1;
            acc_cyc = cyc + 1;
            exp_res = ref_result(Operation, SrcA, SrcB);
            after   = ref_after(Operation, SrcB);
        end else if (m_valid && out_ready) pending = 1'b0;
        cyc++;
    end

    // Compare process: every cycle, 1 time unit after the falling edge.
    always begin
        @(negedge clk);
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!pending && !reset)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (pending && (cyc - acc_cyc >= after))});
        if (pending && (cyc - acc_cyc >= after))
            check("ALUResult", ALUResult, exp_res);
    end

    task automatic wait_ready();
        int n;
        for (n = 0; n < 60; n++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (n == 60) check("wait_in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation, feed garbage while waiting, check latency and value.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        wait_ready();
        in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
        @(negedge clk);
        for (n = 0; n < 40; n++) begin
            if (out_valid) break;
            in_valid = 1'b1; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (n == 40) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, n + 1, lat);
            check({name, "_value"}, ALUResult, exp);
            if (out_ready) begin
                @(negedge clk);
                check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", ALUResult, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("ltu", 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("sra", 4'd6, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
        run_op("mul", 4'd13, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 33);
        run_op("divu", 4'd14, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1);
        run_op("remu", 4'd15, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 33 : 1);
        run_op("divu_z", 4'd14, 32'd5, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1);
        run_op("remu_z", 4'd15, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, 1);

        // Hold the result in DONE for 5 cycles.
        out_ready = 1'b0;
        run_op("hold", 4'd1, 32'h0F0, 32'h00F, 32'h0FF, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_value", ALUResult, 32'h0FF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", {31'd0, in_ready}, 32'd1);
        check("release_valid", {31'd0, out_valid}, 32'd0);

        // Flush at BUSY cycle 10 of a long operation.
        begin
            bit seen;
            wait_ready();
            in_valid = 1'b1; Operation = DIV_EN ? 4'd14 : 4'd13; SrcA = 32'd1000; SrcB = 32'd3;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush_valid", {31'd0, out_valid}, 32'd0);
            check("flush_ready", {31'd0, in_ready}, 32'd1);
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("flush_no_result", {31'd0, seen}, 32'd0);
        end

        // Reset in the middle of a MUL.
        wait_ready();
        in_valid = 1'b1; Operation = 4'd13; SrcA = 32'd12345; SrcB = 32'd678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mid_result", ALUResult, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            Operation = 4'($urandom);
            SrcA      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0:       SrcB = 32'd0;
                1, 2:    SrcB = 32'($urandom_range(1, 40));
                default: SrcB = $urandom;
            endcase
            flush     = ($urandom_range(0, 40) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
